// File: rtl/trash_compactor_pkg.sv
// trash_compactor_pkg: shared types and constants for the streaming worksheet evaluator.
package trash_compactor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // Row index width; a single-row column still needs one bit to hold index 0.
    function automatic int row_index_width(input int num_rows);
        return (num_rows > 1) ? $clog2(num_rows) : 1;
    endfunction

endpackage

// File: rtl/trash_compactor_stream_column_fold.sv
// trash_compactor_stream_column_fold: folds one column of operands into a single
// value with the operator latched on row 0. The column result is held in the
// accumulator and flagged by a one-cycle done pulse after the column's last beat.
// Optional build macro: TRASH_COMPACTOR_OVF_DETECT_EN adds wide arithmetic that
// reports a per-beat overflow pulse; otherwise ovf_o is tied low.
module trash_compactor_stream_column_fold
    import trash_compactor_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int RESULT_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic                    load_i,
    input  logic                    last_i,
    input  logic [DATA_WIDTH-1:0]   operand_i,
    input  logic                    op_i,
    output logic [RESULT_WIDTH-1:0] col_result_o,
    output logic                    col_done_o,
    output logic                    ovf_o
);

    logic [RESULT_WIDTH-1:0] acc_q, acc_d;
    logic [RESULT_WIDTH-1:0] operand_ext, sum, prod;
    logic                    op_q, op_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;
    logic                    sum_carry, prod_high;

    assign operand_ext = RESULT_WIDTH'(operand_i);

`ifdef TRASH_COMPACTOR_OVF_DETECT_EN
    logic [RESULT_WIDTH:0]            sum_w;
    logic [RESULT_WIDTH+DATA_WIDTH-1:0] prod_w;

    assign sum_w     = {1'b0, acc_q} + {1'b0, operand_ext};
    assign prod_w    = (RESULT_WIDTH+DATA_WIDTH)'(acc_q) * (RESULT_WIDTH+DATA_WIDTH)'(operand_i);
    assign sum       = sum_w[RESULT_WIDTH-1:0];
    assign sum_carry = sum_w[RESULT_WIDTH];
    assign prod      = prod_w[RESULT_WIDTH-1:0];
    assign prod_high = |prod_w[RESULT_WIDTH+DATA_WIDTH-1:RESULT_WIDTH];
`else
    assign sum       = acc_q + operand_ext;
    assign prod      = acc_q * operand_ext;
    assign sum_carry = 1'b0;
    assign prod_high = 1'b0;
`endif

    // Next accumulator: load on row 0, otherwise combine with the latched operator.
    always_comb begin
        acc_d  = acc_q;
        op_d   = op_q;
        done_d = 1'b0;
        ovf_d  = 1'b0;
        if (valid_i) begin
            if (load_i) begin
                acc_d = operand_ext;
                op_d  = op_i;
            end else if (op_q == OP_ADD) begin
                acc_d = sum;
                ovf_d = sum_carry;
            end else begin
                acc_d = prod;
                ovf_d = prod_high;
            end
            done_d = last_i;
        end
    end

    // Accumulator, operator and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            op_q   <= OP_MUL;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            op_q   <= op_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end

    assign col_result_o = acc_q;
    assign col_done_o   = done_q;
    assign ovf_o        = ovf_q;

endmodule

// File: rtl/trash_compactor_stream.sv
// trash_compactor_stream: accepts worksheet columns over valid/ready, folds each
// column and accumulates the grand total and the number of completed columns.
// Optional build macro: TRASH_COMPACTOR_OVF_DETECT_EN enables the sticky overflow
// flag; without it overflow stays low and no wide adders are built.
//
// state  | meaning
// IDLE   | waiting for the first start after reset
// ACCEPT | in_ready high, consuming operand beats
// DRAIN  | last column result being added to the total
// DONE   | total published on result/finished, waiting for a new start
module trash_compactor_stream
    import trash_compactor_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_ROWS     = 4,
    parameter int RESULT_WIDTH = 64,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_op,
    input  logic                    in_last,
    output logic                    busy,
    output logic                    finished,
    output logic [RESULT_WIDTH-1:0] result,
    output logic [COUNT_WIDTH-1:0]  col_count,
    output logic                    overflow
);

    localparam int               ROW_W    = row_index_width(NUM_ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    state_e                  state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [RESULT_WIDTH-1:0] total_q, total_d, total_sum;
    logic [RESULT_WIDTH-1:0] result_q, result_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    finished_q, finished_d;
    logic                    ovf_q, ovf_d;
    logic                    beat, last_row, begin_sheet, total_carry;
    logic [RESULT_WIDTH-1:0] col_result;
    logic                    col_done, fold_ovf;

    assign beat     = in_valid && ready_q;
    assign last_row = (row_q == LAST_ROW);

    trash_compactor_stream_column_fold #(
        .DATA_WIDTH   (DATA_WIDTH),
        .RESULT_WIDTH (RESULT_WIDTH)
    ) u_column_fold (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (beat),
        .load_i       (row_q == '0),
        .last_i       (last_row),
        .operand_i    (in_data),
        .op_i         (in_op),
        .col_result_o (col_result),
        .col_done_o   (col_done),
        .ovf_o        (fold_ovf)
    );

`ifdef TRASH_COMPACTOR_OVF_DETECT_EN
    logic [RESULT_WIDTH:0] total_sum_w;

    assign total_sum_w = {1'b0, total_q} + {1'b0, col_result};
    assign total_sum   = total_sum_w[RESULT_WIDTH-1:0];
    assign total_carry = total_sum_w[RESULT_WIDTH];
`else
    assign total_sum   = total_q + col_result;
    assign total_carry = 1'b0;
`endif

    // Next-state logic; start is only honoured outside a running worksheet.
    always_comb begin
        state_d     = state_q;
        begin_sheet = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ACCEPT;
                    begin_sheet = 1'b1;
                end
            end
            ACCEPT: begin
                if (beat && last_row && in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    state_d     = ACCEPT;
                    begin_sheet = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next values: row index, total, column count and published outputs.
    always_comb begin
        row_d      = row_q;
        total_d    = total_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        finished_d = finished_q;
        result_d   = result_q;
        if (begin_sheet) begin
            row_d      = '0;
            total_d    = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
            finished_d = 1'b0;
            result_d   = '0;
        end else begin
            if (beat) begin
                row_d = last_row ? '0 : row_q + 1'b1;
            end
            if (col_done) begin
                total_d = total_sum;
                count_d = count_q + 1'b1;
                ovf_d   = ovf_d | total_carry;
            end
            if (fold_ovf) begin
                ovf_d = 1'b1;
            end
            if (state_q == DONE) begin
                finished_d = 1'b1;
                result_d   = total_q;
            end
        end
        ready_d = (state_d == ACCEPT);
        busy_d  = (state_d == ACCEPT) || (state_d == DRAIN);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q      <= '0;
            total_q    <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            finished_q <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            row_q      <= row_d;
            total_q    <= total_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            finished_q <= finished_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready  = ready_q;
    assign busy      = busy_q;
    assign finished  = finished_q;
    assign result    = result_q;
    assign col_count = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_trash_compactor_stream.sv
// tb_trash_compactor_stream: three instances (3 rows/64 bit, 4 rows/32 bit,
// 1 row/64 bit) driven from one sequence of scenario tasks. A reference model
// builds the beat stream and pushes each worksheet's expected outcome to a
// scoreboard that is popped when the instance raises finished.
module tb_trash_compactor_stream;

    localparam int DW = 16;
    localparam int CW = 16;
`ifdef TRASH_COMPACTOR_OVF_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        logic [63:0] res;
        int          cnt;
        bit          ovf;
        int          beats;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start    [3];
    logic          in_valid [3];
    logic          in_op    [3];
    logic          in_last  [3];
    logic [DW-1:0] in_data  [3];
    wire           in_ready [3];
    wire           busy     [3];
    wire           finished [3];
    wire           overflow [3];
    wire  [CW-1:0] col_count[3];
    wire  [63:0]   result0;
    wire  [31:0]   result1;
    wire  [63:0]   result2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_cnt [3];
    int last_hs[3];
    int hs_base[3];

    exp_t        sb[$];
    logic [15:0] bdata[$];
    logic        bop[$];
    logic        blast[$];
    logic [63:0] m_total;
    int          m_cnt;
    bit          m_ovf;

    always #5 clk = ~clk;

    trash_compactor_stream #(.DATA_WIDTH(DW), .NUM_ROWS(3), .RESULT_WIDTH(64), .COUNT_WIDTH(CW)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_op(in_op[0]), .in_last(in_last[0]), .busy(busy[0]),
        .finished(finished[0]), .result(result0), .col_count(col_count[0]), .overflow(overflow[0]));

    trash_compactor_stream #(.DATA_WIDTH(DW), .NUM_ROWS(4), .RESULT_WIDTH(32), .COUNT_WIDTH(CW)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_op(in_op[1]), .in_last(in_last[1]), .busy(busy[1]),
        .finished(finished[1]), .result(result1), .col_count(col_count[1]), .overflow(overflow[1]));

    trash_compactor_stream #(.DATA_WIDTH(DW), .NUM_ROWS(1), .RESULT_WIDTH(64), .COUNT_WIDTH(CW)) dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_op(in_op[2]), .in_last(in_last[2]), .busy(busy[2]),
        .finished(finished[2]), .result(result2), .col_count(col_count[2]), .overflow(overflow[2]));

    // Handshake monitor: counts consumed beats and remembers the edge of the latest one.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 3; d++) begin
            if (in_valid[d] === 1'b1 && in_ready[d] === 1'b1) begin
                hs_cnt[d]  <= hs_cnt[d] + 1;
                last_hs[d] <= cyc + 1;
            end
        end
    end

    function automatic logic [63:0] res_of(input int d);
        case (d)
            0:       return result0;
            1:       return {32'd0, result1};
            default: return result2;
        endcase
    endfunction

    function automatic int rows_of(input int d);
        case (d)
            0:       return 3;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int rw_of(input int d);
        return (d == 1) ? 32 : 64;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_sheet();
        m_total = '0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        bdata.delete();
        bop.delete();
        blast.delete();
    endtask

    // Reference fold of one column plus its beats; ignored in_op/in_last rows get random values.
    task automatic add_column(input int d, input logic [15:0] v0, input logic [15:0] v1,
                              input logic [15:0] v2, input logic [15:0] v3,
                              input logic op, input bit last);
        logic [15:0]  v[4];
        logic [127:0] wide;
        logic [63:0]  acc, mask;
        int           n, rw;
        v    = '{v0, v1, v2, v3};
        n    = rows_of(d);
        rw   = rw_of(d);
        mask = (rw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << rw) - 64'd1);
        acc  = 64'(v[0]);
        for (int r = 1; r < n; r++) begin
            wide = op ? (128'(acc) + 128'(v[r])) : (128'(acc) * 128'(v[r]));
            if ((wide >> rw) != 128'd0) m_ovf = 1'b1;
            acc = wide[63:0] & mask;
        end
        wide = 128'(m_total) + 128'(acc);
        if ((wide >> rw) != 128'd0) m_ovf = 1'b1;
        m_total = wide[63:0] & mask;
        m_cnt++;
        for (int r = 0; r < n; r++) begin
            bdata.push_back(v[r]);
            bop.push_back((r == 0) ? op : 1'($urandom));
            blast.push_back((r == n - 1) ? last : 1'($urandom));
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.res   = m_total;
        e.cnt   = m_cnt;
        e.ovf   = m_ovf && OVF_EN;
        e.beats = bdata.size();
        sb.push_back(e);
    endtask

    task automatic build_example();
        new_sheet();
        add_column(0, 16'd123, 16'd45,  16'd6,   16'd0, 1'b0, 1'b0);
        add_column(0, 16'd328, 16'd64,  16'd98,  16'd0, 1'b1, 1'b0);
        add_column(0, 16'd51,  16'd387, 16'd215, 16'd0, 1'b0, 1'b0);
        add_column(0, 16'd64,  16'd23,  16'd314, 16'd0, 1'b1, 1'b1);
    endtask

    task automatic pulse_start(input int d);
        start[d]   = 1'b1;
        hs_base[d] = hs_cnt[d];
        tick();
        start[d]   = 1'b0;
    endtask

    // Sends beats [lo,hi) with an idle_pct chance of a garbage idle cycle before each beat.
    task automatic send_beats(input int d, input int lo, input int hi, input int idle_pct);
        int w;
        for (int i = lo; i < hi; i++) begin
            for (int g = 0; g < 8 && $urandom_range(99, 0) < idle_pct; g++) begin
                in_valid[d] = 1'b0;
                in_data[d]  = 16'($urandom);
                in_op[d]    = 1'($urandom);
                in_last[d]  = 1'($urandom);
                tick();
            end
            in_valid[d] = 1'b1;
            in_data[d]  = bdata[i];
            in_op[d]    = bop[i];
            in_last[d]  = blast[i];
            w = 0;
            while (in_ready[d] !== 1'b1 && w < 50) begin
                tick();
                w++;
            end
            if (in_ready[d] !== 1'b1) begin
                n_checks++;
                n_fail++;
                $display("FAIL handshake_timeout dut%0d beat %0d: in_ready=%b required 1", d, i, in_ready[d]);
                in_valid[d] = 1'b0;
                return;
            end
            tick();
        end
        in_valid[d] = 1'b0;
        in_data[d]  = 16'($urandom);
    endtask

    task automatic check_finish(input int d, input string tag);
        exp_t e;
        int   w = 0;
        while (finished[d] !== 1'b1 && w < 60) begin
            tick();
            w++;
        end
        n_checks++;
        if (finished[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_finished dut%0d: finished=%b required 1", tag, d, finished[d]);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_scoreboard dut%0d: queue empty, required an entry", tag, d);
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if (cyc - last_hs[d] !== 2) begin
            n_fail++;
            $display("FAIL %s_latency dut%0d: finished %0d edges after last beat, required 2", tag, d, cyc - last_hs[d]);
        end
        n_checks++;
        if (res_of(d) !== e.res) begin
            n_fail++;
            $display("FAIL %s_result dut%0d: got %0d required %0d", tag, d, res_of(d), e.res);
        end
        n_checks++;
        if (col_count[d] !== 16'(e.cnt)) begin
            n_fail++;
            $display("FAIL %s_col_count dut%0d: got %0d required %0d", tag, d, col_count[d], e.cnt);
        end
        n_checks++;
        if (overflow[d] !== e.ovf) begin
            n_fail++;
            $display("FAIL %s_overflow dut%0d: got %b required %b", tag, d, overflow[d], e.ovf);
        end
        n_checks++;
        if (busy[d] !== 1'b0 || in_ready[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_flags dut%0d: busy=%b in_ready=%b required 0 0", tag, d, busy[d], in_ready[d]);
        end
        n_checks++;
        if (hs_cnt[d] - hs_base[d] !== e.beats) begin
            n_fail++;
            $display("FAIL %s_beats dut%0d: consumed %0d required %0d", tag, d, hs_cnt[d] - hs_base[d], e.beats);
        end
    endtask

    task automatic check_reset_values(input int d, input string tag);
        n_checks++;
        if (in_ready[d] !== 1'b0 || busy[d] !== 1'b0 || finished[d] !== 1'b0 ||
            res_of(d) !== 64'd0 || col_count[d] !== 16'd0 || overflow[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s dut%0d: rdy=%b busy=%b fin=%b res=%0d cnt=%0d ovf=%b required all 0",
                     tag, d, in_ready[d], busy[d], finished[d], res_of(d), col_count[d], overflow[d]);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        for (int d = 0; d < 3; d++) check_reset_values(d, "reset_values");
        rst = 1'b0;
        tick();
        for (int d = 0; d < 3; d++) check_reset_values(d, "after_reset_release");
    endtask

    task automatic test_example();
        build_example();
        push_expected();
        pulse_start(0);
        n_checks++;
        if (in_ready[0] !== 1'b1 || busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL start_response: in_ready=%b busy=%b required 1 1", in_ready[0], busy[0]);
        end
        send_beats(0, 0, bdata.size(), 0);
        check_finish(0, "example");
    endtask

    task automatic test_start_in_done();
        pulse_start(0);
        n_checks++;
        if (finished[0] !== 1'b0 || col_count[0] !== 16'd0 || busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear: finished=%b col_count=%0d busy=%b required 0 0 1",
                     finished[0], col_count[0], busy[0]);
        end
        build_example();
        push_expected();
        send_beats(0, 0, bdata.size(), 0);
        check_finish(0, "restart");
    endtask

    task automatic test_gaps();
        build_example();
        push_expected();
        pulse_start(0);
        send_beats(0, 0, bdata.size(), 60);
        check_finish(0, "gaps");
    endtask

    task automatic test_start_while_busy();
        build_example();
        push_expected();
        pulse_start(0);
        send_beats(0, 0, 6, 0);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        n_checks++;
        if (col_count[0] !== 16'd2 || in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start_ignored: col_count=%0d in_ready=%b required 2 1", col_count[0], in_ready[0]);
        end
        send_beats(0, 6, bdata.size(), 0);
        check_finish(0, "busy_start");
    endtask

    task automatic test_reset_mid();
        build_example();
        pulse_start(0);
        send_beats(0, 0, 4, 0);
        n_checks++;
        if (col_count[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_col_count: got %0d required 1", col_count[0]);
        end
        rst = 1'b1;
        #1;
        check_reset_values(0, "mid_reset_values");
        tick();
        tick();
        rst = 1'b0;
        tick();
        build_example();
        push_expected();
        pulse_start(0);
        send_beats(0, 0, bdata.size(), 0);
        check_finish(0, "after_mid_reset");
    endtask

    task automatic test_overflow();
        new_sheet();
        add_column(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        push_expected();
        pulse_start(1);
        send_beats(1, 0, bdata.size(), 0);
        check_finish(1, "overflow");
    endtask

    task automatic test_single_row();
        new_sheet();
        add_column(2, 16'd5, 16'd0, 16'd0, 16'd0, 1'($urandom), 1'b0);
        add_column(2, 16'd7, 16'd0, 16'd0, 16'd0, 1'($urandom), 1'b0);
        add_column(2, 16'd9, 16'd0, 16'd0, 16'd0, 1'($urandom), 1'b1);
        push_expected();
        pulse_start(2);
        send_beats(2, 0, bdata.size(), 0);
        check_finish(2, "single_row");
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            start[d]    = 1'b0;
            in_valid[d] = 1'b0;
            in_op[d]    = 1'b0;
            in_last[d]  = 1'b0;
            in_data[d]  = '0;
            hs_cnt[d]   = 0;
            last_hs[d]  = 0;
            hs_base[d]  = 0;
        end
        test_reset();
        test_example();
        test_start_in_done();
        test_gaps();
        test_start_while_busy();
        test_reset_mid();
        test_overflow();
        test_single_row();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
